// File: rtl/dyn_array_pkg.sv
// rtl/dyn_array_pkg.sv - shared opcode and state types for the dynamic array store
package dyn_array_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_RESIZE = 2'd2,
        OP_DELETE = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/dyn_array_mem.sv
// rtl/dyn_array_mem.sv - register file, one write port, one async read port, resets to zero
module dyn_array_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (32'(i_widx) < DEPTH)) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    // Guard matters only when DEPTH is not a power of two.
    assign o_rdata = (32'(i_ridx) < DEPTH) ? r_mem[i_ridx] : '0;

endmodule

// File: rtl/dyn_array_store.sv
// rtl/dyn_array_store.sv - dynamic-array store: bounds-checked read/write, resize with clear, delete
module dyn_array_store
    import dyn_array_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_DEPTH = 32,
    parameter int IDX_W     = $clog2(MAX_DEPTH),
    parameter int SIZE_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [IDX_W-1:0]  i_cmd_idx,
    input  logic [SIZE_W-1:0] i_cmd_size,
    input  logic              i_cmd_preserve,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic [SIZE_W-1:0] o_size,
    output logic              o_busy
);

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    state_e            r_state, w_state_nxt;
    logic [SIZE_W-1:0] r_size, w_size_nxt;
    logic [SIZE_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
    logic [SIZE_W-1:0] r_clr_end, w_clr_end_nxt;
    rsp_t              r_rsp, w_rsp_nxt;

    logic              w_accept;
    op_e               w_op;
    logic              w_idx_ok;
    logic              w_size_ok;
    logic [SIZE_W-1:0] w_clr_start;
    logic              w_we;
    logic [IDX_W-1:0]  w_widx;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_accept    = i_cmd_valid && (r_state == ST_IDLE);
    assign w_op        = op_e'(i_cmd_op);
    assign w_idx_ok    = SIZE_W'(i_cmd_idx) < r_size;
    assign w_size_ok   = i_cmd_size <= SIZE_W'(MAX_DEPTH);
    assign w_clr_start = i_cmd_preserve ? r_size : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_size_nxt    = r_size;
        w_clr_ptr_nxt = r_clr_ptr;
        w_clr_end_nxt = r_clr_end;
        w_rsp_nxt     = '0;
        w_we          = 1'b0;
        w_widx        = '0;
        w_wdata       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_rsp_nxt.valid = 1'b1;
                    case (w_op)
                        OP_READ: begin
                            if (w_idx_ok) w_rsp_nxt.data = w_rdata;
                            else          w_rsp_nxt.err  = 1'b1;
                        end
                        OP_WRITE: begin
                            if (w_idx_ok) begin
                                w_we    = 1'b1;
                                w_widx  = i_cmd_idx;
                                w_wdata = i_cmd_data;
                            end else begin
                                w_rsp_nxt.err = 1'b1;
                            end
                        end
                        OP_RESIZE: begin
                            if (!w_size_ok) begin
                                w_rsp_nxt.err = 1'b1;
                            end else if (i_cmd_size > w_clr_start) begin
                                // Response is deferred until the last entry of the range is zeroed.
                                w_rsp_nxt.valid = 1'b0;
                                w_state_nxt     = ST_CLEAR;
                                w_clr_ptr_nxt   = w_clr_start;
                                w_clr_end_nxt   = i_cmd_size;
                            end else begin
                                w_size_nxt = i_cmd_size;
                            end
                        end
                        OP_DELETE: begin
                            w_size_nxt = '0;
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                w_we   = 1'b1;
                w_widx = r_clr_ptr[IDX_W-1:0];
                if (r_clr_ptr == r_clr_end - SIZE_W'(1)) begin
                    w_state_nxt     = ST_IDLE;
                    w_size_nxt      = r_clr_end;
                    w_rsp_nxt.valid = 1'b1;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + SIZE_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_size    <= '0;
            r_clr_ptr <= '0;
            r_clr_end <= '0;
            r_rsp     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_size    <= w_size_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_clr_end <= w_clr_end_nxt;
            r_rsp     <= w_rsp_nxt;
        end
    end

    dyn_array_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_widx  (w_widx),
        .i_wdata (w_wdata),
        .i_ridx  (i_cmd_idx),
        .o_rdata (w_rdata)
    );

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state == ST_CLEAR);
    assign o_size      = r_size;
    assign o_rsp_valid = r_rsp.valid;
    assign o_rsp_err   = r_rsp.err;
    assign o_rsp_data  = r_rsp.data;

endmodule

// File: tb/tb_dyn_array_store.sv
// tb/tb_dyn_array_store.sv - directed table, randomized model comparison and reset-mid-clear for dyn_array_store
module tb_dyn_array_store;

    localparam int DW   = 8;
    localparam int MAXD = 32;
    localparam int IW   = $clog2(MAXD);
    localparam int SW   = $clog2(MAXD + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [1:0]    i_cmd_op = '0;
    logic [IW-1:0] i_cmd_idx = '0;
    logic [SW-1:0] i_cmd_size = '0;
    logic          i_cmd_preserve = 1'b0;
    logic [DW-1:0] i_cmd_data = '0;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_err;
    logic [SW-1:0] o_size;
    logic          o_busy;

    int checks = 0;
    int errors = 0;

    int       m_size;
    bit [7:0] m_mem [MAXD];

    dyn_array_store #(.DATA_W(DW), .MAX_DEPTH(MAXD)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_op       (i_cmd_op),
        .i_cmd_idx      (i_cmd_idx),
        .i_cmd_size     (i_cmd_size),
        .i_cmd_preserve (i_cmd_preserve),
        .i_cmd_data     (i_cmd_data),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_data     (o_rsp_data),
        .o_rsp_err      (o_rsp_err),
        .o_size         (o_size),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_size = 0;
        for (int i = 0; i < MAXD; i++) m_mem[i] = 8'h00;
    endtask

    // Dynamic-array semantics: new[n] zeroes everything, new[n](arr) zeroes only the growth.
    task automatic model_apply(input int op, input int idx, input int sz, input bit pres,
                               input bit [7:0] dat, output bit e_err, output bit [7:0] e_data,
                               output int e_lat, output int e_busy);
        int lo;
        e_err = 0; e_data = 0; e_lat = 1; e_busy = 0;
        case (op)
            0: if (idx < m_size) e_data = m_mem[idx]; else e_err = 1;
            1: if (idx < m_size) m_mem[idx] = dat; else e_err = 1;
            2: begin
                if (sz > MAXD) begin
                    e_err = 1;
                end else begin
                    lo = pres ? m_size : 0;
                    for (int i = lo; i < sz; i++) m_mem[i] = 8'h00;
                    e_busy = (sz > lo) ? sz - lo : 0;
                    e_lat  = e_busy + 1;
                    m_size = sz;
                end
            end
            default: m_size = 0;
        endcase
    endtask

    task automatic issue(input int op, input int idx, input int sz, input bit pres,
                         input bit [7:0] dat, input int old_size,
                         output int lat, output int busy_n, output bit held,
                         output logic err, output logic [7:0] data, output int size_after);
        @(negedge clk);
        chk("ready_before_cmd", o_cmd_ready, 1);
        i_cmd_valid    = 1'b1;
        i_cmd_op       = 2'(op);
        i_cmd_idx      = IW'(idx);
        i_cmd_size     = SW'(sz);
        i_cmd_preserve = pres;
        i_cmd_data     = dat;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        i_cmd_idx   = IW'($urandom);
        i_cmd_size  = SW'($urandom);
        lat = 1; busy_n = 0; held = 1;
        while (!o_rsp_valid && lat < 40) begin
            if (o_busy) busy_n++;
            if (o_size != SW'(old_size)) held = 0;
            @(posedge clk);
            #1;
            lat++;
        end
        err        = o_rsp_err;
        data       = o_rsp_data;
        size_after = o_size;
        @(posedge clk);
        #1;
        chk("rsp_one_cycle", o_rsp_valid, 0);
    endtask

    typedef struct {
        int       op;
        int       idx;
        int       sz;
        bit       pres;
        bit [7:0] dat;
        bit       e_err;
        bit [7:0] e_data;
        int       e_lat;
        int       e_busy;
        int       e_size;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int lat, busy_n, size_after, old, m_lat, m_busy, op, idx, sz;
        bit held, m_err, pres;
        bit [7:0] m_data, dat;
        logic err;
        logic [7:0] data;

        //        op idx sz  p  dat    err data   lat busy size
        tbl = '{
            '{0,  0,  0, 0, 8'h00, 1, 8'h00, 1, 0, 0},
            '{2,  0,  8, 0, 8'h00, 0, 8'h00, 9, 8, 8},
            '{1,  3,  0, 0, 8'hA5, 0, 8'h00, 1, 0, 8},
            '{0,  3,  0, 0, 8'h00, 0, 8'hA5, 1, 0, 8},
            '{0,  8,  0, 0, 8'h00, 1, 8'h00, 1, 0, 8},
            '{2,  0, 16, 1, 8'h00, 0, 8'h00, 9, 8, 16},
            '{0,  3,  0, 0, 8'h00, 0, 8'hA5, 1, 0, 16},
            '{0, 12,  0, 0, 8'h00, 0, 8'h00, 1, 0, 16},
            '{2,  0,  4, 1, 8'h00, 0, 8'h00, 1, 0, 4},
            '{0,  3,  0, 0, 8'h00, 0, 8'hA5, 1, 0, 4},
            '{2,  0, 33, 0, 8'h00, 1, 8'h00, 1, 0, 4},
            '{1,  1,  0, 0, 8'h5C, 0, 8'h00, 1, 0, 4},
            '{1,  4,  0, 0, 8'h77, 1, 8'h00, 1, 0, 4},
            '{3,  0,  0, 0, 8'h00, 0, 8'h00, 1, 0, 0},
            '{0,  0,  0, 0, 8'h00, 1, 8'h00, 1, 0, 0},
            '{2,  0,  2, 1, 8'h00, 0, 8'h00, 3, 2, 2},
            '{0,  0,  0, 0, 8'h00, 0, 8'h00, 1, 0, 2},
            '{0,  1,  0, 0, 8'h00, 0, 8'h00, 1, 0, 2}
        };

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", o_rsp_valid, 0);
        chk("reset_rsp_err", o_rsp_err, 0);
        chk("reset_rsp_data", o_rsp_data, 0);
        chk("reset_size", o_size, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_ready", o_cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            old = m_size;
            model_apply(tbl[i].op, tbl[i].idx, tbl[i].sz, tbl[i].pres, tbl[i].dat,
                        m_err, m_data, m_lat, m_busy);
            issue(tbl[i].op, tbl[i].idx, tbl[i].sz, tbl[i].pres, tbl[i].dat, old,
                  lat, busy_n, held, err, data, size_after);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].e_lat);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
            chk($sformatf("tbl%0d_data", i), data, tbl[i].e_data);
            chk($sformatf("tbl%0d_size", i), size_after, tbl[i].e_size);
            chk($sformatf("tbl%0d_busy", i), busy_n, tbl[i].e_busy);
            if (tbl[i].e_busy > 0) chk($sformatf("tbl%0d_size_hold", i), held, 1);
        end

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            op = (r < 40) ? 0 : (r < 75) ? 1 : (r < 96) ? 2 : 3;
            if (m_size > 0 && $urandom_range(0, 3) != 0) idx = $urandom_range(0, m_size - 1);
            else idx = $urandom_range(0, MAXD - 1);
            sz   = $urandom_range(0, MAXD + 1);
            pres = 1'($urandom);
            dat  = 8'($urandom);
            old  = m_size;
            model_apply(op, idx, sz, pres, dat, m_err, m_data, m_lat, m_busy);
            issue(op, idx, sz, pres, dat, old, lat, busy_n, held, err, data, size_after);
            chk("rnd_lat", lat, m_lat);
            chk("rnd_err", err, m_err);
            chk("rnd_data", data, m_data);
            chk("rnd_size", size_after, m_size);
            chk("rnd_busy", busy_n, m_busy);
            if (m_busy > 0) chk("rnd_size_hold", held, 1);
        end

        // Reset asserted during the fifth clear cycle of a full-depth resize.
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_op = 2'd2; i_cmd_size = SW'(MAXD); i_cmd_preserve = 1'b0;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        chk("midclr_busy_c1", o_busy, 1);
        repeat (4) @(posedge clk);
        #2;
        chk("midclr_busy_c5", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", o_rsp_valid, 0);
        chk("midrst_size", o_size, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_ready", o_cmd_ready, 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_rsp", o_rsp_valid, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_rsp", o_rsp_valid, 0);
            chk("post_rst_ready", o_cmd_ready, 1);
            chk("post_rst_size", o_size, 0);
        end

        old = m_size;
        model_apply(0, 0, 0, 0, 0, m_err, m_data, m_lat, m_busy);
        issue(0, 0, 0, 0, 0, old, lat, busy_n, held, err, data, size_after);
        chk("post_rst_read_err", err, 1);
        chk("post_rst_read_lat", lat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
